// File: rtl/rx_acq_ctrl.sv
// rx_acq_ctrl: acquisition and lock supervision for the receive chain.
// Watches channel-sample energy over fixed windows. Holds the timing and
// carrier loops in soft reset until a signal is present. Then sequences
// settle, acquire and locked phases, and re-arms the chain after a timeout,
// a lock loss or a signal loss.
//
// Handshake: rx_valid and sym_strobe are single-cycle qualifiers with no
// back-pressure. A strobe counts only on the cycle it is high, and the two
// strobes are processed independently when they coincide. demod_lock is
// only looked at on cycles where sym_strobe is high.
module rx_acq_ctrl #(
  parameter int          WIN_LOG2       = 6,
  parameter logic [18:0] ENERGY_THR     = 19'd32768,
  parameter int          SETTLE_SYMS    = 64,
  parameter int          ACQ_TIMEOUT    = 1024,
  parameter int          LOCK_CONFIRM   = 16,
  parameter int          UNLOCK_CONFIRM = 8,
  parameter int          HOLDOFF_CYC    = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic signed [11:0] rx_I,
  input  logic signed [11:0] rx_Q,
  input  logic               rx_valid,
  input  logic               sym_strobe,
  input  logic               demod_lock,
  output logic               loops_rst_n,
  output logic               out_gate,
  output logic               locked,
  output logic [2:0]         state,
  output logic               lock_lost,
  output logic               acq_fail,
  output logic [7:0]         retry_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DETECT  = 3'd1,
    S_SETTLE  = 3'd2,
    S_ACQUIRE = 3'd3,
    S_LOCKED  = 3'd4,
    S_HOLDOFF = 3'd5
  } state_t;

  // The symbol counter serves both SETTLE and ACQUIRE, and the run counter
  // serves both the lock run and the unlock run, so each is sized for the
  // larger of its two limits.
  localparam int SYM_MAX = (SETTLE_SYMS > ACQ_TIMEOUT) ? SETTLE_SYMS : ACQ_TIMEOUT;
  localparam int RUN_MAX = (LOCK_CONFIRM > UNLOCK_CONFIRM) ? LOCK_CONFIRM : UNLOCK_CONFIRM;
  localparam int SW = $clog2(SYM_MAX + 1);
  localparam int RW = $clog2(RUN_MAX + 1);
  localparam int HW = $clog2(HOLDOFF_CYC + 1);

  localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE_SYMS);
  localparam logic [SW-1:0] ACQ_END    = SW'(ACQ_TIMEOUT);
  localparam logic [RW-1:0] LOCK_END   = RW'(LOCK_CONFIRM);
  localparam logic [RW-1:0] UNLOCK_END = RW'(UNLOCK_CONFIRM);
  localparam logic [HW-1:0] HOLD_END   = HW'(HOLDOFF_CYC);

  state_t              state_q, state_n;
  logic [18:0]         acc_q, acc_n;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_n;
  logic [SW-1:0]       sym_q, sym_n;
  logic [RW-1:0]       run_q, run_n;
  logic [HW-1:0]       hold_q, hold_n;
  logic                fail_n, lost_n;
  logic [7:0]          retry_n;

  // Magnitudes are 12-bit unsigned, so -2048 folds to 2048 with no overflow.
  logic [11:0] raw_i, raw_q, mag_i, mag_q;
  logic [18:0] acc_sum;
  logic        monitor_on, win_close, win_hi, win_low;
  logic [SW-1:0] sym_inc;
  logic [RW-1:0] run_inc;
  logic [HW-1:0] hold_inc;

  assign raw_i    = rx_I;
  assign raw_q    = rx_Q;
  assign mag_i    = raw_i[11] ? (~raw_i + 12'd1) : raw_i;
  assign mag_q    = raw_q[11] ? (~raw_q + 12'd1) : raw_q;
  assign acc_sum  = acc_q + 19'(mag_i) + 19'(mag_q);

  assign monitor_on = (state_q == S_DETECT) || (state_q == S_SETTLE) ||
                      (state_q == S_ACQUIRE) || (state_q == S_LOCKED);
  assign win_close  = monitor_on && rx_valid && (win_cnt_q == '1);
  assign win_hi     = (acc_sum >= ENERGY_THR);
  assign win_low    = win_close && !win_hi;

  assign sym_inc  = sym_q + SW'(1);
  assign run_inc  = run_q + RW'(1);
  assign hold_inc = hold_q + HW'(1);

  assign state = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_n;
  end

  // Next state, counter updates and event pulses.
  always_comb begin
    state_n   = state_q;
    acc_n     = acc_q;
    win_cnt_n = win_cnt_q;
    sym_n     = sym_q;
    run_n     = run_q;
    hold_n    = hold_q;
    fail_n    = 1'b0;
    lost_n    = 1'b0;
    retry_n   = retry_cnt;

    if (monitor_on) begin
      if (rx_valid) begin
        if (win_close) begin
          acc_n     = '0;
          win_cnt_n = '0;
        end else begin
          acc_n     = acc_sum;
          win_cnt_n = win_cnt_q + WIN_LOG2'(1);
        end
      end
    end else begin
      acc_n     = '0;
      win_cnt_n = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (enable) state_n = S_DETECT;
      end
      S_DETECT: begin
        if (win_close && win_hi) state_n = S_SETTLE;
      end
      S_SETTLE: begin
        if (sym_strobe) sym_n = sym_inc;
        if (win_low)                                  state_n = S_DETECT;
        else if (sym_strobe && sym_inc == SETTLE_END) state_n = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        if (sym_strobe) begin
          sym_n = sym_inc;
          run_n = demod_lock ? run_inc : '0;
        end
        // Signal loss beats everything; a lock on the timeout strobe still wins.
        if (win_low) begin
          state_n = S_DETECT;
        end else if (sym_strobe && demod_lock && run_inc == LOCK_END) begin
          state_n = S_LOCKED;
        end else if (sym_strobe && sym_inc == ACQ_END) begin
          state_n = S_HOLDOFF;
          fail_n  = 1'b1;
        end
      end
      S_LOCKED: begin
        if (sym_strobe) run_n = demod_lock ? '0 : run_inc;
        // Both exit causes share one pulse and one retry increment.
        if (win_low || (sym_strobe && !demod_lock && run_inc == UNLOCK_END)) begin
          state_n = S_HOLDOFF;
          lost_n  = 1'b1;
        end
      end
      S_HOLDOFF: begin
        hold_n = hold_inc;
        if (hold_inc == HOLD_END) state_n = S_DETECT;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Dropping enable overrides every transition and suppresses the pulses.
    if (!enable) begin
      state_n = S_IDLE;
      fail_n  = 1'b0;
      lost_n  = 1'b0;
    end

    if (state_n != state_q) begin
      acc_n     = '0;
      win_cnt_n = '0;
      sym_n     = '0;
      run_n     = '0;
      hold_n    = '0;
    end

    if ((fail_n || lost_n) && retry_cnt != 8'hFF) retry_n = retry_cnt + 8'd1;
  end

  // Counters and registered outputs; gate and soft reset follow the state register by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      win_cnt_q   <= '0;
      sym_q       <= '0;
      run_q       <= '0;
      hold_q      <= '0;
      loops_rst_n <= 1'b0;
      out_gate    <= 1'b0;
      locked      <= 1'b0;
      lock_lost   <= 1'b0;
      acq_fail    <= 1'b0;
      retry_cnt   <= 8'd0;
    end else begin
      acc_q       <= acc_n;
      win_cnt_q   <= win_cnt_n;
      sym_q       <= sym_n;
      run_q       <= run_n;
      hold_q      <= hold_n;
      loops_rst_n <= (state_q == S_SETTLE) || (state_q == S_ACQUIRE) || (state_q == S_LOCKED);
      out_gate    <= (state_q == S_LOCKED);
      locked      <= (state_q == S_LOCKED);
      lock_lost   <= lost_n;
      acq_fail    <= fail_n;
      retry_cnt   <= retry_n;
    end
  end

endmodule

// File: tb/tb_rx_acq_ctrl.sv
// Bench for rx_acq_ctrl: directed scenarios plus a randomized soak, all
// compared cycle by cycle against a behavioural model of the controller.
module tb_rx_acq_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, enable, rx_valid, sym_strobe, demod_lock;
  logic signed [11:0] rx_I, rx_Q;
  logic               loops_rst_n, out_gate, locked, lock_lost, acq_fail;
  logic [2:0]         state;
  logic [7:0]         retry_cnt;

  rx_acq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .rx_I       (rx_I),
    .rx_Q       (rx_Q),
    .rx_valid   (rx_valid),
    .sym_strobe (sym_strobe),
    .demod_lock (demod_lock),
    .loops_rst_n(loops_rst_n),
    .out_gate   (out_gate),
    .locked     (locked),
    .state      (state),
    .lock_lost  (lock_lost),
    .acq_fail   (acq_fail),
    .retry_cnt  (retry_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus controls: amplitude mode 0 = constant +512, 1 = random 400..600
  // either sign, 2 = zero, 3 = random full scale.
  int amp_mode   = 0;
  bit samples_on = 1'b1;
  int vcnt       = 0;

  // ---------------- behavioural model ----------------
  int m_st, m_sym, m_run, m_hold, m_retry;
  int win_mags[$];
  bit m_loops, m_locked, m_fail, m_lost;

  function automatic int absv(input logic signed [11:0] v);
    int x;
    x = int'(v);
    return (x < 0) ? -x : x;
  endfunction

  function automatic void model_step();
    int nxt, sum;
    bit close, hi, lo, fail, lost;
    if (!rst_n) begin
      m_st = 0; m_sym = 0; m_run = 0; m_hold = 0; m_retry = 0;
      win_mags.delete();
      m_loops = 0; m_locked = 0; m_fail = 0; m_lost = 0;
      return;
    end
    nxt = m_st; close = 0; hi = 0; fail = 0; lost = 0;
    if (m_st >= 1 && m_st <= 4 && rx_valid) begin
      win_mags.push_back(absv(rx_I) + absv(rx_Q));
      if (win_mags.size() == 64) begin
        sum = 0;
        foreach (win_mags[i]) sum += win_mags[i];
        close = 1;
        hi = (sum >= 32768);
        win_mags.delete();
      end
    end
    lo = close && !hi;
    if ((m_st == 2 || m_st == 3) && sym_strobe) m_sym++;
    case (m_st)
      0: if (enable) nxt = 1;
      1: if (close && hi) nxt = 2;
      2: if (lo) nxt = 1; else if (m_sym == 64) nxt = 3;
      3: begin
        if (sym_strobe) m_run = demod_lock ? m_run + 1 : 0;
        if (lo) nxt = 1;
        else if (m_run == 16) nxt = 4;
        else if (m_sym == 1024) begin nxt = 5; fail = 1; end
      end
      4: begin
        if (sym_strobe) m_run = demod_lock ? 0 : m_run + 1;
        if (lo || m_run == 8) begin nxt = 5; lost = 1; end
      end
      5: begin
        m_hold++;
        if (m_hold == 256) nxt = 1;
      end
      default: nxt = 0;
    endcase
    if (!enable) begin nxt = 0; fail = 0; lost = 0; end
    m_loops  = (m_st >= 2 && m_st <= 4);
    m_locked = (m_st == 4);
    m_fail   = fail;
    m_lost   = lost;
    if ((fail || lost) && m_retry < 255) m_retry++;
    if (nxt != m_st) begin m_sym = 0; m_run = 0; m_hold = 0; win_mags.delete(); end
    m_st = nxt;
  endfunction

  function automatic logic [15:0] dut_vec();
    return {state, loops_rst_n, out_gate, locked, lock_lost, acq_fail, retry_cnt};
  endfunction

  function automatic logic [15:0] mdl_vec();
    return {3'(m_st), m_loops, m_locked, m_locked, m_lost, m_fail, 8'(m_retry)};
  endfunction

  // ---------------- driver ----------------
  function automatic logic signed [11:0] pick(input int mode);
    int mag;
    case (mode)
      0:       return 12'sd512;
      1:       mag = int'($urandom_range(600, 400));
      2:       mag = 0;
      default: mag = int'($urandom_range(2048, 0));
    endcase
    if (mag == 2048 || $urandom_range(1, 0) == 1) return 12'(-mag);
    return 12'(mag);
  endfunction

  // Drives one cycle of inputs, advances the model, and returns #1 after the edge.
  task automatic step(input bit s, input bit l);
    sym_strobe = s;
    demod_lock = l;
    rx_valid   = samples_on && (vcnt % 4 == 0);
    vcnt++;
    rx_I = pick(amp_mode);
    rx_Q = pick(amp_mode);
    model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; samples_on = 1'b1; amp_mode = 3;
    repeat (4) begin
      step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      n_checks++;
      if (dut_vec() !== 16'h0000) begin
        n_errors++;
        $display("FAIL reset_values: got %h expected 0000", dut_vec());
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    enable = 1'b0; amp_mode = 3;
    for (int k = 0; k < 100; k++) begin
      step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      n_checks++;
      if (state !== 3'd0 || loops_rst_n !== 1'b0 || dut_vec() !== mdl_vec()) begin
        n_errors++;
        $display("FAIL idle_hold k=%0d: got state=%0d loops_rst_n=%b vec=%h expected state=0 loops_rst_n=0 vec=%h",
                 k, state, loops_rst_n, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_detect_settle(input int mode);
    int n;
    logic [2:0] exp_st;
    amp_mode = mode;
    if (enable !== 1'b1) begin
      enable = 1'b1;
      step(1'b0, 1'b0);
      n_checks++;
      if (state !== 3'd1) begin
        n_errors++;
        $display("FAIL idle_exit: got state=%0d expected 1", state);
      end
    end
    n = 0;
    while (n < 64) begin
      step(1'b0, 1'b0);
      if (rx_valid) n++;
      exp_st = (n == 64) ? 3'd2 : 3'd1;
      n_checks++;
      if (state !== exp_st || dut_vec() !== mdl_vec()) begin
        n_errors++;
        $display("FAIL detect_window n=%0d: got state=%0d vec=%h expected state=%0d vec=%h",
                 n, state, dut_vec(), exp_st, mdl_vec());
      end
    end
    for (int k = 1; k <= 64 * 16; k++) begin
      step(k % 16 == 0, 1'($urandom_range(1, 0)));
      exp_st = (k == 64 * 16) ? 3'd3 : 3'd2;
      n_checks++;
      if (state !== exp_st || dut_vec() !== mdl_vec()) begin
        n_errors++;
        $display("FAIL settle_count k=%0d: got state=%0d vec=%h expected state=%0d vec=%h",
                 k, state, dut_vec(), exp_st, mdl_vec());
      end
      if (k == 1) begin
        n_checks++;
        if (loops_rst_n !== 1'b1) begin
          n_errors++;
          $display("FAIL settle_release: got loops_rst_n=%b expected 1", loops_rst_n);
        end
      end
    end
  endtask

  task automatic test_acq_timeout();
    int low;
    logic [2:0] exp_st;
    amp_mode = 1;
    for (int k = 1; k <= 1024 * 8; k++) begin
      step(k % 8 == 0, 1'b0);
      exp_st = (k == 1024 * 8) ? 3'd5 : 3'd3;
      n_checks++;
      if (state !== exp_st || acq_fail !== (k == 1024 * 8) || dut_vec() !== mdl_vec()) begin
        n_errors++;
        $display("FAIL acq_timeout k=%0d: got state=%0d acq_fail=%b vec=%h expected state=%0d vec=%h",
                 k, state, acq_fail, dut_vec(), exp_st, mdl_vec());
      end
    end
    n_checks++;
    if (retry_cnt !== 8'd1) begin
      n_errors++;
      $display("FAIL timeout_retry: got retry_cnt=%0d expected 1", retry_cnt);
    end
    low = 0;
    for (int k = 1; k <= 256; k++) begin
      step(1'b0, 1'b0);
      if (loops_rst_n === 1'b0) low++;
      exp_st = (k == 256) ? 3'd1 : 3'd5;
      n_checks++;
      if (state !== exp_st || acq_fail !== 1'b0 || dut_vec() !== mdl_vec()) begin
        n_errors++;
        $display("FAIL holdoff_timing k=%0d: got state=%0d acq_fail=%b vec=%h expected state=%0d vec=%h",
                 k, state, acq_fail, dut_vec(), exp_st, mdl_vec());
      end
    end
    n_checks++;
    if (low != 256) begin
      n_errors++;
      $display("FAIL holdoff_soft_reset: got %0d low cycles expected 256", low);
    end
  endtask

  task automatic test_acquire_success();
    bit pat[$];
    logic [2:0] exp_st;
    amp_mode = 1;
    repeat (15) pat.push_back(1'b1);
    pat.push_back(1'b0);
    repeat (16) pat.push_back(1'b1);
    for (int i = 1; i <= 32; i++) begin
      repeat (15) begin
        step(1'b0, 1'($urandom_range(1, 0)));
        n_checks++;
        if (dut_vec() !== mdl_vec()) begin
          n_errors++;
          $display("FAIL acquire_gap strobe=%0d: got vec=%h expected vec=%h", i, dut_vec(), mdl_vec());
        end
      end
      step(1'b1, pat[i-1]);
      exp_st = (i == 32) ? 3'd4 : 3'd3;
      n_checks++;
      if (state !== exp_st || out_gate !== 1'b0 || dut_vec() !== mdl_vec()) begin
        n_errors++;
        $display("FAIL acquire_lock strobe=%0d: got state=%0d out_gate=%b vec=%h expected state=%0d out_gate=0 vec=%h",
                 i, state, out_gate, dut_vec(), exp_st, mdl_vec());
      end
    end
    step(1'b0, 1'b1);
    n_checks++;
    if (out_gate !== 1'b1 || locked !== 1'b1 || dut_vec() !== mdl_vec()) begin
      n_errors++;
      $display("FAIL gate_rise: got out_gate=%b locked=%b vec=%h expected out_gate=1 locked=1 vec=%h",
               out_gate, locked, dut_vec(), mdl_vec());
    end
  endtask

  task automatic test_lock_loss();
    bit pat[$];
    int pulses;
    logic [2:0] exp_st;
    amp_mode = 1;
    repeat (7) pat.push_back(1'b0);
    pat.push_back(1'b1);
    repeat (8) pat.push_back(1'b0);
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      repeat (7) begin
        step(1'b0, 1'($urandom_range(1, 0)));
        if (lock_lost === 1'b1) pulses++;
        n_checks++;
        if (dut_vec() !== mdl_vec()) begin
          n_errors++;
          $display("FAIL lock_loss_gap strobe=%0d: got vec=%h expected vec=%h", i, dut_vec(), mdl_vec());
        end
      end
      step(1'b1, pat[i-1]);
      if (lock_lost === 1'b1) pulses++;
      exp_st = (i == 16) ? 3'd5 : 3'd4;
      n_checks++;
      if (state !== exp_st || lock_lost !== (i == 16) || dut_vec() !== mdl_vec()) begin
        n_errors++;
        $display("FAIL lock_loss strobe=%0d: got state=%0d lock_lost=%b vec=%h expected state=%0d vec=%h",
                 i, state, lock_lost, dut_vec(), exp_st, mdl_vec());
      end
    end
    for (int k = 1; k <= 256; k++) begin
      step(1'b0, 1'b0);
      if (lock_lost === 1'b1) pulses++;
      exp_st = (k == 256) ? 3'd1 : 3'd5;
      n_checks++;
      if (state !== exp_st || dut_vec() !== mdl_vec()) begin
        n_errors++;
        $display("FAIL loss_holdoff k=%0d: got state=%0d vec=%h expected state=%0d vec=%h",
                 k, state, dut_vec(), exp_st, mdl_vec());
      end
    end
    n_checks++;
    if (pulses != 1 || retry_cnt !== 8'd2) begin
      n_errors++;
      $display("FAIL lock_loss_pulse: got pulses=%0d retry_cnt=%0d expected pulses=1 retry_cnt=2", pulses, retry_cnt);
    end
  endtask

  task automatic test_zero_loss();
    int k;
    bit hit;
    amp_mode = 2;
    hit = 0;
    k = 0;
    while (!hit && k < 400) begin
      step(k % 8 == 7, 1'b1);
      k++;
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_errors++;
        $display("FAIL zero_loss k=%0d: got vec=%h expected vec=%h", k, dut_vec(), mdl_vec());
      end
      if (state === 3'd5) hit = 1;
    end
    n_checks++;
    if (!hit || lock_lost !== 1'b1 || retry_cnt !== 8'd3 || k > 64 * 4 + 4) begin
      n_errors++;
      $display("FAIL zero_loss_exit: got state=%0d lock_lost=%b retry_cnt=%0d after %0d cycles expected state=5 lock_lost=1 retry_cnt=3 within 260",
               state, lock_lost, retry_cnt, k);
    end
    amp_mode = 1;
    for (int j = 1; j <= 256; j++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if (dut_vec() !== mdl_vec()) begin
        n_errors++;
        $display("FAIL zero_holdoff j=%0d: got vec=%h expected vec=%h", j, dut_vec(), mdl_vec());
      end
    end
    n_checks++;
    if (state !== 3'd1) begin
      n_errors++;
      $display("FAIL zero_rearm: got state=%0d expected 1", state);
    end
  endtask

  task automatic test_enable_drop();
    amp_mode = 1;
    for (int k = 0; k < 40; k++) begin
      step(k % 8 == 7, 1'($urandom_range(1, 0)));
      n_checks++;
      if (state !== 3'd3 || dut_vec() !== mdl_vec()) begin
        n_errors++;
        $display("FAIL drop_pre k=%0d: got state=%0d vec=%h expected state=3 vec=%h", k, state, dut_vec(), mdl_vec());
      end
    end
    enable = 1'b0;
    step(1'b1, 1'b1);
    n_checks++;
    if (state !== 3'd0 || acq_fail !== 1'b0 || lock_lost !== 1'b0 || retry_cnt !== 8'd3) begin
      n_errors++;
      $display("FAIL enable_drop: got state=%0d acq_fail=%b lock_lost=%b retry_cnt=%0d expected 0 0 0 3",
               state, acq_fail, lock_lost, retry_cnt);
    end
    step(1'b0, 1'b0);
    n_checks++;
    if (state !== 3'd0 || loops_rst_n !== 1'b0 || out_gate !== 1'b0 || dut_vec() !== mdl_vec()) begin
      n_errors++;
      $display("FAIL enable_drop_outputs: got state=%0d loops_rst_n=%b out_gate=%b expected 0 0 0",
               state, loops_rst_n, out_gate);
    end
  endtask

  task automatic test_soak();
    int lock_pct, sper, r;
    for (int seg = 0; seg < 30; seg++) begin
      r = int'($urandom_range(9, 0));
      amp_mode = (r < 6) ? 1 : ((r < 8) ? 3 : 2);
      lock_pct = int'($urandom_range(100, 70));
      sper = int'($urandom_range(8, 2));
      enable = ($urandom_range(9, 0) != 0);
      for (int k = 0; k < 600; k++) begin
        rst_n = ($urandom_range(2999, 0) != 0);
        step(int'($urandom_range(sper - 1, 0)) == 0, int'($urandom_range(99, 0)) < lock_pct);
        n_checks++;
        if (dut_vec() !== mdl_vec()) begin
          n_errors++;
          $display("FAIL soak seg=%0d k=%0d: got vec=%h expected vec=%h", seg, k, dut_vec(), mdl_vec());
        end
      end
    end
    rst_n = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; enable = 1'b0; rx_valid = 1'b0; sym_strobe = 1'b0; demod_lock = 1'b0;
    rx_I = '0; rx_Q = '0;
    test_reset();
    test_idle();
    test_detect_settle(0);
    test_acq_timeout();
    test_detect_settle(1);
    test_acquire_success();
    test_lock_loss();
    test_detect_settle(1);
    test_acquire_success();
    test_zero_loss();
    test_detect_settle(1);
    test_enable_drop();
    test_soak();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
